// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: M-extension funct3 codes, mul/div FSM states, XLEN.
package riscv_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [2:0] MD_MUL    = 3'b000;
   localparam logic [2:0] MD_MULH   = 3'b001;
   localparam logic [2:0] MD_MULHSU = 3'b010;
   localparam logic [2:0] MD_MULHU  = 3'b011;
   localparam logic [2:0] MD_DIV    = 3'b100;
   localparam logic [2:0] MD_DIVU   = 3'b101;
   localparam logic [2:0] MD_REM    = 3'b110;
   localparam logic [2:0] MD_REMU   = 3'b111;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_FIX  = 2'd2,
      MD_DONE = 2'd3
   } md_state_t;

endpackage

// File: rtl/muldiv_unit_if.sv
// Issue/result bundle between the EX stage and the iterative mul/div unit.
interface muldiv_unit_if;
   import riscv_pkg::*;

   logic            start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] rs1;
   logic [XLEN-1:0] rs2;
   logic            flush;
   logic            stall;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output start, funct3, rs1, rs2, flush,
      input  stall, done, result
   );

   modport slave (
      input  start, funct3, rs1, rs2, flush,
      output stall, done, result
   );

endinterface

// File: rtl/muldiv_datapath.sv
// Shared shift-add multiply / restoring divide datapath with sign fix-up.
module muldiv_datapath
   import riscv_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic            special,
   input  logic            step,
   input  logic            fix,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            special_c,
   output logic [XLEN-1:0] result
);

   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   logic [2:0]      op_q;
   logic            neg_q;
   logic            rem_neg_q;
   logic [XLEN-1:0] hi_q;
   logic [XLEN-1:0] lo_q;
   logic [XLEN-1:0] opd_q;

   logic            is_div_c;
   logic            a_signed_c;
   logic            b_signed_c;
   logic            neg_a_c;
   logic            neg_b_c;
   logic            div_zero_c;
   logic            div_ovf_c;
   logic [XLEN-1:0] mag_a_c;
   logic [XLEN-1:0] mag_b_c;
   logic [XLEN-1:0] special_res_c;

   logic [XLEN:0]     sum_c;
   logic [XLEN:0]     rdiv_c;
   logic              ge_c;
   logic [XLEN-1:0]   hi_step_c;
   logic [XLEN-1:0]   lo_step_c;
   logic [2*XLEN-1:0] prod_c;
   logic [XLEN-1:0]   fix_res_c;

   // Decode signedness and magnitudes of the issue operands; flag special divides
   always_comb begin
      is_div_c   = funct3[2];
      a_signed_c = (funct3 == MD_MULH) | (funct3 == MD_MULHSU) |
                   (funct3 == MD_DIV)  | (funct3 == MD_REM);
      b_signed_c = (funct3 == MD_MULH) | (funct3 == MD_DIV) | (funct3 == MD_REM);
      neg_a_c    = a_signed_c & rs1[XLEN-1];
      neg_b_c    = b_signed_c & rs2[XLEN-1];
      mag_a_c    = neg_a_c ? -rs1 : rs1;
      mag_b_c    = neg_b_c ? -rs2 : rs2;
      div_zero_c = is_div_c & (rs2 == '0);
      div_ovf_c  = is_div_c & ~funct3[0] & (rs1 == INT_MIN) & (rs2 == '1);
      special_c  = div_zero_c | div_ovf_c;
      if (div_zero_c) begin
         special_res_c = funct3[1] ? rs1 : '1;
      end else begin
         special_res_c = funct3[1] ? '0 : INT_MIN;
      end
   end

   // One iteration: add-then-shift for multiply, shift/trial-subtract for divide
   always_comb begin
      sum_c  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
      rdiv_c = {hi_q, lo_q[XLEN-1]};
      ge_c   = rdiv_c >= {1'b0, opd_q};
      if (op_q[2]) begin
         // remainder stays below the divisor, so the low word of the difference is exact
         hi_step_c = ge_c ? (rdiv_c[XLEN-1:0] - opd_q) : rdiv_c[XLEN-1:0];
         lo_step_c = {lo_q[XLEN-2:0], ge_c};
      end else begin
         hi_step_c = sum_c[XLEN:1];
         lo_step_c = {sum_c[0], lo_q[XLEN-1:1]};
      end
   end

   // Restore signs and pick the requested word
   always_comb begin
      prod_c = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
      case (op_q)
         MD_MUL:                       fix_res_c = prod_c[XLEN-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU: fix_res_c = prod_c[2*XLEN-1:XLEN];
         MD_DIV, MD_DIVU:              fix_res_c = neg_q ? -lo_q : lo_q;
         default:                      fix_res_c = rem_neg_q ? -hi_q : hi_q;
      endcase
   end

   // Operand/accumulator registers and the result register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q      <= MD_MUL;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         opd_q     <= '0;
         result    <= '0;
      end else begin
         if (load) begin
            op_q      <= funct3;
            neg_q     <= neg_a_c ^ neg_b_c;
            rem_neg_q <= neg_a_c;
            hi_q      <= '0;
            lo_q      <= is_div_c ? mag_a_c : mag_b_c;
            opd_q     <= is_div_c ? mag_b_c : mag_a_c;
         end else if (step) begin
            hi_q <= hi_step_c;
            lo_q <= lo_step_c;
         end
         if (fix) begin
            result <= fix_res_c;
         end else if (special) begin
            result <= special_res_c;
         end
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M mul/div unit: sequencing FSM, step counter, stall and done.
module muldiv_unit
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN = 32
)
(
   input  logic          clk,
   input  logic          rst_n,
   muldiv_unit_if.slave  bus
);

   localparam int unsigned CNT_W = $clog2(XLEN);

   localparam logic [1:0] S_IDLE = MD_IDLE;
   localparam logic [1:0] S_CALC = MD_CALC;
   localparam logic [1:0] S_FIX  = MD_FIX;
   localparam logic [1:0] S_DONE = MD_DONE;

   logic [1:0]       state_q;
   logic [1:0]       state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             done_q;
   logic             done_d;

   logic load_c;
   logic special_ld_c;
   logic step_c;
   logic fix_c;
   logic special_c;

   // Next-state, counter and datapath strobes
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      done_d       = 1'b0;
      load_c       = 1'b0;
      special_ld_c = 1'b0;
      step_c       = 1'b0;
      fix_c        = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start && !bus.flush) begin
               if (special_c) begin
                  state_d      = S_DONE;
                  special_ld_c = 1'b1;
                  done_d       = 1'b1;
               end else begin
                  state_d = S_CALC;
                  cnt_d   = CNT_W'(XLEN - 1);
                  load_c  = 1'b1;
               end
            end
         end
         S_CALC: begin
            if (bus.flush) begin
               state_d = S_IDLE;
            end else begin
               step_c = 1'b1;
               if (cnt_q == '0) begin
                  state_d = S_FIX;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         S_FIX: begin
            if (bus.flush) begin
               state_d = S_IDLE;
            end else begin
               fix_c   = 1'b1;
               state_d = S_DONE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, counter and done pulse registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   // Pipeline hold covers the accept cycle and all busy cycles, but not DONE
   assign bus.stall = ((state_q == S_IDLE) & bus.start & ~bus.flush) |
                      (state_q == S_CALC) | (state_q == S_FIX);
   assign bus.done  = done_q;

   muldiv_datapath u_dp (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load_c),
      .special   (special_ld_c),
      .step      (step_c),
      .fix       (fix_c),
      .funct3    (bus.funct3),
      .rs1       (bus.rs1),
      .rs2       (bus.rs2),
      .special_c (special_c),
      .result    (bus.result)
   );

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit with a cycle-level reference model.
module tb_muldiv_unit;
   import riscv_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   muldiv_unit_if bus();

   muldiv_unit #(.XLEN(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   bit cmp_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Architectural RV32M results, including the divide corner cases
   function automatic logic ref_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      return f[2] && ((b == 32'h0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
   endfunction

   function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'h0, a});
      ub = longint'({32'h0, b});
      p  = 64'h0;
      if (f[2] && b == 32'h0) return f[1] ? a : 32'hFFFF_FFFF;
      if (ref_special(f, a, b)) return f[1] ? 32'h0 : 32'h8000_0000;
      case (f)
         3'd0: begin p = 64'(sa * sb); return p[31:0];  end
         3'd1: begin p = 64'(sa * sb); return p[63:32]; end
         3'd2: begin p = 64'(sa * ub); return p[63:32]; end
         3'd3: begin p = 64'(ua * ub); return p[63:32]; end
         3'd4: begin p = 64'(sa / sb); return p[31:0];  end
         3'd5: begin p = 64'(ua / ub); return p[31:0];  end
         3'd6: begin p = 64'(sa % sb); return p[31:0];  end
         default: begin p = 64'(ua % ub); return p[31:0]; end
      endcase
   endfunction

   // Timeline model: cycles left until the done cycle, pending and last result
   int          m_left = 0;
   bit          m_done = 1'b0;
   logic [31:0] m_pend = 32'h0;
   logic [31:0] m_last = 32'h0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left = 0;
         m_done = 1'b0;
         m_last = 32'h0;
      end else if (m_done) begin
         m_done = 1'b0;
      end else if (m_left > 0) begin
         if (bus.flush) begin
            m_left = 0;
         end else begin
            m_left--;
            if (m_left == 0) begin
               m_done = 1'b1;
               m_last = m_pend;
            end
         end
      end else if (bus.start && !bus.flush) begin
         if (ref_special(bus.funct3, bus.rs1, bus.rs2)) begin
            m_done = 1'b1;
            m_last = ref_op(bus.funct3, bus.rs1, bus.rs2);
         end else begin
            m_left = 33;
            m_pend = ref_op(bus.funct3, bus.rs1, bus.rs2);
         end
      end
   end

   // Every-cycle comparison of stall, done and the result register
   always @(negedge clk) begin
      if (cmp_en) begin
         logic es;
         es = (m_left > 0) || (!m_done && bus.start && !bus.flush);
         chk("stall", 32'(bus.stall), 32'(es));
         chk("done", 32'(bus.done), 32'(m_done));
         chk("result", bus.result, m_last);
      end
   end

   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, output int t0);
      @(posedge clk); #1;
      bus.start  = 1'b1;
      bus.flush  = 1'b0;
      bus.funct3 = f;
      bus.rs1    = a;
      bus.rs2    = b;
      t0 = cyc;
      @(posedge clk); #1;
      bus.start  = 1'b0;
      bus.funct3 = 3'($urandom);
      bus.rs1    = $urandom;
      bus.rs2    = $urandom;
   endtask

   task automatic wait_done(input int t0, input int lat, input logic [31:0] exp, input string name);
      bit got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (bus.done) begin
            got = 1'b1;
            chk({name, " latency"}, 32'(cyc - t0), 32'(lat));
            chk({name, " value"}, bus.result, exp);
         end
      end
      if (!got) begin
         n_chk++;
         n_err++;
         $display("FAIL %s timeout: done never seen, expected at accept+%0d", name, lat);
      end
   endtask

   task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input int lat, input string name);
      int t0;
      issue(f, a, b, t0);
      wait_done(t0, lat, exp, name);
   endtask

   initial begin
      int t0;
      logic [2:0]  f;
      logic [31:0] a, b;
      bus.start  = 1'b0;
      bus.flush  = 1'b0;
      bus.funct3 = 3'b0;
      bus.rs1    = 32'h0;
      bus.rs2    = 32'h0;

      #2;
      chk("reset stall", 32'(bus.stall), 32'h0);
      chk("reset done", 32'(bus.done), 32'h0);
      chk("reset result", bus.result, 32'h0);
      #20;
      rst_n  = 1'b1;
      cmp_en = 1'b1;

      run(MD_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "mul 7*-3");
      run(MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu");
      run(MD_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34, "mulh");
      run(MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, "mulhsu");
      run(MD_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, "mulh minmin");
      run(MD_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, "div -7/2");
      run(MD_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, "rem -7/2");
      run(MD_DIVU,   32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 34, "divu");
      run(MD_REMU,   32'd7,         32'd2,         32'd1,         34, "remu 7/2");
      run(MD_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1,  "div by zero");
      run(MD_REMU,   32'd5,         32'd0,         32'd5,         1,  "remu by zero");
      run(MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  "div overflow");
      run(MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1,  "rem overflow");

      // flush at T+10, new request at T+11
      issue(MD_DIV, 32'd100, 32'd7, t0);
      repeat (9) @(posedge clk);
      #1 bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush  = 1'b0;
      bus.start  = 1'b1;
      bus.funct3 = MD_REMU;
      bus.rs1    = 32'd7;
      bus.rs2    = 32'd2;
      t0 = cyc;
      @(posedge clk); #1;
      bus.start = 1'b0;
      wait_done(t0, 34, 32'd1, "after flush");

      // start together with flush in IDLE is refused
      @(posedge clk); #1;
      bus.start  = 1'b1;
      bus.flush  = 1'b1;
      bus.funct3 = MD_MUL;
      bus.rs1    = 32'd3;
      bus.rs2    = 32'd3;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      @(negedge clk);
      chk("start+flush stall", 32'(bus.stall), 32'h0);
      chk("start+flush done", 32'(bus.done), 32'h0);

      // start pulses while busy are ignored
      issue(MD_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, t0);
      repeat (5) @(posedge clk);
      #1;
      bus.start = 1'b1; bus.funct3 = MD_DIV; bus.rs1 = 32'd9; bus.rs2 = 32'd0;
      @(posedge clk); #1 bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      bus.start = 1'b1; bus.funct3 = MD_MUL; bus.rs1 = 32'd2; bus.rs2 = 32'd2;
      @(posedge clk); #1 bus.start = 1'b0;
      wait_done(t0, 34, ref_op(MD_MULHU, 32'h1234_5678, 32'h9ABC_DEF0), "busy ignore");

      // asynchronous reset in the middle of a multiply
      issue(MD_MUL, 32'd123, 32'd456, t0);
      repeat (19) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("async rst stall", 32'(bus.stall), 32'h0);
      chk("async rst done", 32'(bus.done), 32'h0);
      chk("async rst result", bus.result, 32'h0);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      run(MD_MUL, 32'd123, 32'd456, 32'd56088, 34, "mul after reset");

      // a few mixed operations checked against the model
      for (int i = 0; i < 8; i++) begin
         f = 3'($urandom);
         a = $urandom;
         b = (i % 4 == 1) ? 32'h0 : $urandom;
         run(f, a, b, ref_op(f, a, b), ref_special(f, a, b) ? 1 : 34, "mixed");
      end

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit in the EX stage of the five-stage pipeline, beside the main ALU. It accepts one M-extension operation at a time and sequences a shared 32-step shift-add or restoring-divide datapath. It holds the pipeline with `stall` until the result is ready, then presents it for exactly one cycle.

## Interface
Parameters:
- `XLEN`, default 32: operand and result width. Only 32 is supported; the step counter is sized from it.

Ports:
- `clk`: input, 1 bit. Rising-edge clock.
- `rst_n`: input, 1 bit. Reset is asynchronous and active-low.
- `start`: input, 1 bit. Issue request; sampled only in IDLE.
- `funct3`: input, 3 bits. Operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1`: input, XLEN. Multiplicand or dividend.
- `rs2`: input, XLEN. Multiplier or divisor.
- `flush`: input, 1 bit. Abort the current operation (branch mispredict or trap).
- `stall`: output, 1 bit. Holds IF/ID/EX; combinational.
- `done`: output, 1 bit. Result valid; 1-cycle pulse.
- `result`: output, XLEN. Registered result; meaningful only while `done`=1.

## Operation
- States are IDLE, CALC, FIX and DONE.
- IDLE→CALC on `start`=1 and `flush`=0.
  - Latch `funct3`, sign flags and operand magnitudes.
  - Load the step counter with 31.
- IDLE→DONE directly on a special divide; the result is latched at the same edge.
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give `rs1`.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- CALC performs one step per cycle; CALC→FIX when the counter reaches 0 (32 steps).
- Multiply steps:
  - Operands are taken as magnitudes: signed for MULH (both operands), rs1 only for MULHSU, neither for MUL/MULHU.
  - Each step is a conditional add into the 64-bit accumulator, followed by a shift.
- Divide steps:
  - Restoring division on magnitudes, signed for DIV/REM.
  - Each step shifts, trial-subtracts, and sets the quotient bit on non-negative.
- FIX:
  - Negate the product if the operand signs differ.
  - Negate the quotient if the signs differ.
  - Give the remainder the sign of the dividend.
  - Select the low word for MUL and the high word for MULH/MULHSU/MULHU.
  - Register the result. FIX→DONE.
- DONE: `done`=1 for one cycle, then DONE→IDLE unconditionally. `start` in DONE is ignored.
- `flush`=1 in CALC or FIX: next state is IDLE, no `done`, and `result` is not updated.
- `flush` in DONE: the pulse still completes; the pipeline discards it.
- `flush`=1 with `start`=1 in IDLE: flush wins and the request is not accepted.
- `start` while not IDLE: ignored; no queueing.

## Timing
- Reset values: state IDLE, `stall`=0, `done`=0, `result`=0, counter 0, accumulators 0.
- `rst_n` low mid-operation aborts immediately, with no `done`.
- `stall` = (IDLE & `start` & ~`flush`) | CALC | FIX.
- Normal operation accepted at cycle T:
  - CALC occupies T+1..T+32, FIX is T+33 and DONE is T+34.
  - `stall`=1 for T..T+33, and `done`=1 at T+34 with `stall`=0, so the instruction advances with its result.
- Special divide accepted at T: `stall`=1 at T only; `done`=1 at T+1.
- Back-to-back: the earliest next accept is T+35 (normal case) or T+2 (special divide).
- `rs1`, `rs2` and `funct3` are sampled only in the accept cycle; later changes have no effect.

## Structure
- Shared package `riscv_pkg` holds:
  - the funct3 constants `MD_MUL` … `MD_REMU`;
  - the state enum `md_state_t`;
  - `XLEN`.
- The natural split is one sub-module, `muldiv_datapath`: accumulators, step logic and sign fix-up, driven by a step/fix strobe.
- The FSM, counter, stall and done logic live in `muldiv_unit`.

## Test plan
- MUL: `rs1`=7, `rs2`=0xFFFFFFFD, start at T → `stall` high T..T+33, `done` at T+34 with 0xFFFFFFEB.
- High multiply with both operands 0xFFFFFFFF:
  - MULHU → 0xFFFFFFFE.
  - MULH → 0x00000000.
  - MULHSU → 0xFFFFFFFF.
- Divide:
  - DIV -7/2 → 0xFFFFFFFD.
  - REM -7/2 → 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC.
  - REMU 7/2 → 1.
- Special divides, each `done` at T+1 with `stall` high only at T:
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/-1 → 0x80000000.
  - REM 0x80000000/-1 → 0.
- Flush and start edge cases:
  - `flush` at T+10 → IDLE at T+11, no `done`, `result` unchanged.
  - A new `start` at T+11 is accepted.
  - `start`+`flush` together in IDLE → not accepted.
- Reset and busy behaviour:
  - `rst_n` low at T+20 → all outputs reset asynchronously.
  - After release, a new MUL completes normally.
  - `start` pulses during CALC are ignored.
